// File: rtl/testdrive_intr_pkg.sv
// testdrive_intr_pkg: shared types and helpers for the simulation interrupt controller.
// Rev 1.0
`default_nettype none

package testdrive_intr_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } intr_state_e;

  localparam int ARB_FIXED       = 0;
  localparam int ARB_ROUND_ROBIN = 1;

  function automatic int intr_id_width(input int count);
    int w;
    w = $clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/testdrive_intr_arbiter.sv
// testdrive_intr_arbiter: combinational priority picker, first request at or above ptr_i (wrapping).
// Rev 1.0
`default_nettype none

module testdrive_intr_arbiter #(
  parameter int C_COUNT = 8,
  parameter int IDW     = 3
) (
  input  logic [C_COUNT-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic               valid_o,
  output logic [IDW-1:0]     id_o
);

  int             idx;
  logic [IDW-1:0] sel;

  // Fixed priority is simply this search with ptr_i tied to zero.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < C_COUNT; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= C_COUNT) idx = idx - C_COUNT;
      sel = IDW'(idx);
      if (!valid_o && req_i[sel]) begin
        valid_o = 1'b1;
        id_o    = sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/testdrive_intr_ctrl.sv
// testdrive_intr_ctrl: multi-source edge/level interrupt controller with a held, acknowledged IRQ.
// Rev 1.0
`default_nettype none

module testdrive_intr_ctrl
  import testdrive_intr_pkg::*;
#(
  parameter int                 C_COUNT       = 8,
  parameter logic [C_COUNT-1:0] C_EDGE        = {C_COUNT{1'b1}},
  parameter logic [C_COUNT-1:0] C_ACTIVE      = {C_COUNT{1'b1}},
  parameter int                 C_ROUND_ROBIN = ARB_FIXED,
  parameter int                 IDW           = intr_id_width(C_COUNT)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               EN,
  input  logic [C_COUNT-1:0] INTR,
  input  logic [C_COUNT-1:0] MASK,
  output logic               IRQ,
  output logic [IDW-1:0]     IRQ_ID,
  input  logic               ACK,
  input  logic [IDW-1:0]     ACK_ID,
  output logic               ACK_ERR,
  output logic [C_COUNT-1:0] PENDING,
  output logic [C_COUNT-1:0] OVERFLOW
);

  logic [C_COUNT-1:0] act, prev_act, rise;
  logic [C_COUNT-1:0] prev_q;
  logic [C_COUNT-1:0] pend_q, pend_d;
  logic [C_COUNT-1:0] ovf_q, ovf_d;
  logic [C_COUNT-1:0] cand;
  intr_state_e        state_q;
  logic               irq_q, ack_err_q;
  logic [IDW-1:0]     irq_id_q, ptr_q, arb_ptr, arb_id, ptr_next;
  logic               arb_valid, valid_ack, withdraw;

  assign act      = INTR ~^ C_ACTIVE;
  assign prev_act = prev_q ~^ C_ACTIVE;
  assign rise     = act & ~prev_act & MASK & {C_COUNT{EN}};

  assign valid_ack = ACK && (state_q == S_REQ) && (ACK_ID == irq_id_q);

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < C_COUNT; i++) begin
      if (C_EDGE[i]) begin
        // A fresh edge coinciding with the acknowledge re-arms the source.
        if (valid_ack && (irq_id_q == IDW'(i))) begin
          ovf_d[i]  = 1'b0;
          pend_d[i] = rise[i];
        end else if (rise[i]) begin
          if (pend_q[i]) ovf_d[i]  = 1'b1;
          else           pend_d[i] = 1'b1;
        end
      end else begin
        pend_d[i] = act[i] & MASK[i] & EN;
        ovf_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      prev_q <= ~C_ACTIVE;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      prev_q <= INTR;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cand    = pend_q & MASK;
  assign arb_ptr = (C_ROUND_ROBIN == ARB_ROUND_ROBIN) ? ptr_q : '0;

  testdrive_intr_arbiter #(
    .C_COUNT (C_COUNT),
    .IDW     (IDW)
  ) u_arbiter (
    .req_i   (cand),
    .ptr_i   (arb_ptr),
    .valid_o (arb_valid),
    .id_o    (arb_id)
  );

  assign withdraw = ~(pend_d[irq_id_q] & MASK[irq_id_q]);
  assign ptr_next = (ACK_ID == IDW'(C_COUNT - 1)) ? '0 : ACK_ID + 1'b1;

  // IRQ trails entry into S_REQ by one cycle but drops on the same edge as the exit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      ack_err_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      ack_err_q <= ACK && !valid_ack;
      case (state_q)
        S_IDLE: begin
          irq_q <= 1'b0;
          if (arb_valid) begin
            irq_id_q <= arb_id;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          if (valid_ack) begin
            irq_q   <= 1'b0;
            ptr_q   <= ptr_next;
            state_q <= S_GAP;
          end else if (withdraw) begin
            irq_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            irq_q <= 1'b1;
          end
        end
        S_GAP: begin
          irq_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign IRQ      = irq_q;
  assign IRQ_ID   = irq_id_q;
  assign ACK_ERR  = ack_err_q;
  assign PENDING  = pend_q;
  assign OVERFLOW = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_testdrive_intr_ctrl.sv
// tb_testdrive_intr_ctrl: directed bench; fixed-priority and round-robin instances share stimulus.
// Source 3 is level-mode, source 0 is active-low; all others edge, active-high.
`default_nettype none

module tb_testdrive_intr_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       EN;
  logic [7:0] INTR;
  logic [7:0] MASK;
  logic       ACK;
  logic [2:0] ACK_ID;

  logic       f_irq, f_err, r_irq, r_err;
  logic [2:0] f_id, r_id;
  logic [7:0] f_pend, f_ovf, r_pend, r_ovf;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  testdrive_intr_ctrl #(
    .C_COUNT(8), .C_EDGE(8'hF7), .C_ACTIVE(8'hFE), .C_ROUND_ROBIN(0)
  ) u_fix (
    .CLK(CLK), .nRST(nRST), .EN(EN), .INTR(INTR), .MASK(MASK),
    .IRQ(f_irq), .IRQ_ID(f_id), .ACK(ACK), .ACK_ID(ACK_ID),
    .ACK_ERR(f_err), .PENDING(f_pend), .OVERFLOW(f_ovf)
  );

  testdrive_intr_ctrl #(
    .C_COUNT(8), .C_EDGE(8'hF7), .C_ACTIVE(8'hFE), .C_ROUND_ROBIN(1)
  ) u_rr (
    .CLK(CLK), .nRST(nRST), .EN(EN), .INTR(INTR), .MASK(MASK),
    .IRQ(r_irq), .IRQ_ID(r_id), .ACK(ACK), .ACK_ID(ACK_ID),
    .ACK_ERR(r_err), .PENDING(r_pend), .OVERFLOW(r_ovf)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] intr_val);
    nRST = 1'b0; EN = 1'b1; MASK = 8'hFF; INTR = intr_val; ACK = 1'b0; ACK_ID = 3'd0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic do_ack(input logic [2:0] id);
    ACK = 1'b1; ACK_ID = id;
    tick();
    ACK = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(8'h01);
    vectors++; if (f_irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b exp 0", f_irq); end
    vectors++; if (f_id !== 3'd0) begin miscompares++; $display("FAIL reset_id got %0d exp 0", f_id); end
    vectors++; if (f_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", f_err); end
    vectors++; if (f_pend !== 8'h00) begin miscompares++; $display("FAIL reset_pend got %h exp 00", f_pend); end
    vectors++; if (f_ovf !== 8'h00) begin miscompares++; $display("FAIL reset_ovf got %h exp 00", f_ovf); end
    tick();
    vectors++; if (f_pend !== 8'h00 || f_irq !== 1'b0) begin miscompares++; $display("FAIL reset_idle pend %h irq %b exp 00/0", f_pend, f_irq); end
  endtask

  task automatic test_edge_latency();
    do_reset(8'h01);
    INTR = 8'h21; tick(); INTR = 8'h01;
    vectors++; if (f_pend !== 8'h20 || f_irq !== 1'b0) begin miscompares++; $display("FAIL lat_n1 pend %h irq %b exp 20/0", f_pend, f_irq); end
    tick();
    vectors++; if (f_irq !== 1'b0) begin miscompares++; $display("FAIL lat_n2 irq got %b exp 0", f_irq); end
    tick();
    vectors++; if (f_irq !== 1'b1 || f_id !== 3'd5) begin miscompares++; $display("FAIL lat_n3 irq %b id %0d exp 1/5", f_irq, f_id); end
    do_ack(3'd5);
    vectors++; if (f_irq !== 1'b0 || f_pend !== 8'h00 || f_err !== 1'b0) begin miscompares++; $display("FAIL lat_ack irq %b pend %h err %b exp 0/00/0", f_irq, f_pend, f_err); end
    repeat (3) tick();
    vectors++; if (f_irq !== 1'b0) begin miscompares++; $display("FAIL lat_idle irq got %b exp 0", f_irq); end
  endtask

  task automatic test_fixed_priority();
    do_reset(8'h01);
    INTR = 8'h45; tick(); INTR = 8'h01;
    vectors++; if (f_pend !== 8'h44) begin miscompares++; $display("FAIL fix_pend got %h exp 44", f_pend); end
    repeat (2) tick();
    vectors++; if (f_irq !== 1'b1 || f_id !== 3'd2) begin miscompares++; $display("FAIL fix_first irq %b id %0d exp 1/2", f_irq, f_id); end
    do_ack(3'd2);
    vectors++; if (f_irq !== 1'b0 || f_pend !== 8'h40) begin miscompares++; $display("FAIL fix_gap irq %b pend %h exp 0/40", f_irq, f_pend); end
    repeat (3) tick();
    vectors++; if (f_irq !== 1'b1 || f_id !== 3'd6) begin miscompares++; $display("FAIL fix_second irq %b id %0d exp 1/6", f_irq, f_id); end
    do_ack(3'd6);
    vectors++; if (f_irq !== 1'b0 || f_pend !== 8'h00) begin miscompares++; $display("FAIL fix_done irq %b pend %h exp 0/00", f_irq, f_pend); end
  endtask

  task automatic test_round_robin();
    do_reset(8'h01);
    INTR = 8'h45; tick(); INTR = 8'h01;
    repeat (2) tick();
    vectors++; if (r_irq !== 1'b1 || r_id !== 3'd2) begin miscompares++; $display("FAIL rr_first irq %b id %0d exp 1/2", r_irq, r_id); end
    do_ack(3'd2);
    repeat (3) tick();
    vectors++; if (r_irq !== 1'b1 || r_id !== 3'd6) begin miscompares++; $display("FAIL rr_second irq %b id %0d exp 1/6", r_irq, r_id); end
    do_ack(3'd6);
    // pointer is now 7: the scan wraps to 2 ahead of 6
    INTR = 8'h45; tick(); INTR = 8'h01;
    repeat (2) tick();
    vectors++; if (r_irq !== 1'b1 || r_id !== 3'd2) begin miscompares++; $display("FAIL rr_wrap irq %b id %0d exp 1/2", r_irq, r_id); end
    INTR = 8'h03;
    do_ack(3'd2);
    INTR = 8'h01;
    vectors++; if (r_pend !== 8'h42) begin miscompares++; $display("FAIL rr_pend got %h exp 42", r_pend); end
    repeat (3) tick();
    vectors++; if (r_irq !== 1'b1 || r_id !== 3'd6) begin miscompares++; $display("FAIL rr_ptr irq %b id %0d exp 1/6", r_irq, r_id); end
  endtask

  task automatic test_level();
    int waited;
    do_reset(8'h01);
    INTR = 8'h09;
    repeat (3) tick();
    vectors++; if (f_irq !== 1'b1 || f_id !== 3'd3) begin miscompares++; $display("FAIL lvl_req irq %b id %0d exp 1/3", f_irq, f_id); end
    do_ack(3'd3);
    vectors++; if (f_irq !== 1'b0 || f_pend !== 8'h08 || f_err !== 1'b0) begin miscompares++; $display("FAIL lvl_ack irq %b pend %h err %b exp 0/08/0", f_irq, f_pend, f_err); end
    waited = 0;
    while (f_irq !== 1'b1 && waited < 8) begin tick(); waited++; end
    vectors++; if (f_irq !== 1'b1 || f_id !== 3'd3) begin miscompares++; $display("FAIL lvl_rearm irq %b id %0d exp 1/3 after %0d cycles", f_irq, f_id, waited); end
    INTR = 8'h01; tick();
    vectors++; if (f_irq !== 1'b0 || f_err !== 1'b0) begin miscompares++; $display("FAIL lvl_withdraw irq %b err %b exp 0/0", f_irq, f_err); end
    tick();
    vectors++; if (f_irq !== 1'b0 || f_err !== 1'b0 || f_pend !== 8'h00) begin miscompares++; $display("FAIL lvl_after irq %b err %b pend %h exp 0/0/00", f_irq, f_err, f_pend); end
  endtask

  task automatic test_overflow();
    do_reset(8'h01);
    INTR = 8'h03; tick();
    INTR = 8'h01; tick();
    INTR = 8'h03; tick();
    INTR = 8'h01;
    vectors++; if (f_ovf !== 8'h02 || f_pend !== 8'h02) begin miscompares++; $display("FAIL ovf_set ovf %h pend %h exp 02/02", f_ovf, f_pend); end
    vectors++; if (f_irq !== 1'b1 || f_id !== 3'd1) begin miscompares++; $display("FAIL ovf_req irq %b id %0d exp 1/1", f_irq, f_id); end
    do_ack(3'd1);
    vectors++; if (f_ovf !== 8'h00 || f_pend !== 8'h00) begin miscompares++; $display("FAIL ovf_clr ovf %h pend %h exp 00/00", f_ovf, f_pend); end
  endtask

  task automatic test_bad_ack();
    do_reset(8'h01);
    INTR = 8'h00; tick(); INTR = 8'h01;
    repeat (2) tick();
    vectors++; if (f_irq !== 1'b1 || f_id !== 3'd0) begin miscompares++; $display("FAIL bad_req irq %b id %0d exp 1/0", f_irq, f_id); end
    do_ack(3'd4);
    vectors++; if (f_err !== 1'b1 || f_irq !== 1'b1 || f_id !== 3'd0 || f_pend !== 8'h01) begin miscompares++; $display("FAIL bad_id err %b irq %b id %0d pend %h exp 1/1/0/01", f_err, f_irq, f_id, f_pend); end
    tick();
    vectors++; if (f_err !== 1'b0) begin miscompares++; $display("FAIL bad_pulse err got %b exp 0", f_err); end
    do_ack(3'd0);
    vectors++; if (f_err !== 1'b0 || f_irq !== 1'b0) begin miscompares++; $display("FAIL bad_valid err %b irq %b exp 0/0", f_err, f_irq); end
    tick();
    do_ack(3'd0);
    vectors++; if (f_err !== 1'b1 || f_id !== 3'd0 || f_irq !== 1'b0) begin miscompares++; $display("FAIL bad_idle err %b id %0d irq %b exp 1/0/0", f_err, f_id, f_irq); end
  endtask

  task automatic test_active_low_reset();
    int waited;
    int rises;
    do_reset(8'h00);
    waited = 0;
    while (f_irq !== 1'b1 && waited < 8) begin tick(); waited++; end
    vectors++; if (f_irq !== 1'b1 || f_id !== 3'd0) begin miscompares++; $display("FAIL al_first irq %b id %0d exp 1/0 after %0d cycles", f_irq, f_id, waited); end
    do_ack(3'd0);
    rises = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (f_irq === 1'b1) rises++; end
    vectors++; if (rises !== 0 || f_pend !== 8'h00) begin miscompares++; $display("FAIL al_once irq cycles %0d pend %h exp 0/00", rises, f_pend); end
    INTR = 8'h20; tick(); INTR = 8'h00;
    repeat (2) tick();
    vectors++; if (f_irq !== 1'b1 || f_id !== 3'd5) begin miscompares++; $display("FAIL al_req5 irq %b id %0d exp 1/5", f_irq, f_id); end
    nRST = 1'b0;
    #1;
    vectors++; if (f_irq !== 1'b0 || f_pend !== 8'h00 || f_ovf !== 8'h00) begin miscompares++; $display("FAIL async_rst irq %b pend %h ovf %h exp 0/00/00", f_irq, f_pend, f_ovf); end
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; EN = 1'b0; MASK = 8'hFF; INTR = 8'h01; ACK = 1'b0; ACK_ID = 3'd0;
    test_reset();
    test_edge_latency();
    test_fixed_priority();
    test_round_robin();
    test_level();
    test_overflow();
    test_bad_ack();
    test_active_low_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
